instruction_fetch_unit: RTL and testbench

Upstream fetch/decode stage for the single-cycle MIPS-subset datapath. Holds the PC and presents imem_addr to an external instruction memory. Decodes the returned word into register fields, immediate and datapath control signals. Computes next PC from the datapath's zero and jRrs feedback, and the jal return value for pcStore.

---
 rtl/ifu_pkg.sv | 59 +++++
 rtl/instruction_decoder.sv | 78 +++++++
 rtl/instruction_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared opcode/funct constants, ALU codes, state and next-PC class encodings
// for the instruction fetch unit and its decoder.
package ifu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // How the next PC is formed for a legal instruction.
    typedef enum logic [2:0] {
        IC_SEQ  = 3'd0,
        IC_BEQ  = 3'd1,
        IC_BNE  = 3'd2,
        IC_JUMP = 3'd3,
        IC_JR   = 3'd4
    } iclass_e;

    typedef struct packed {
        logic    reg_wr;
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu;
        logic    mem_wr;
        logic    mem_to_reg;
        logic    jl;
    } ctrl_t;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational decode of one instruction word into datapath controls,
// a legality flag and the next-PC class.
module instruction_decoder
    import ifu_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        legal,
    output iclass_e     iclass
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        ctrl   = '0;
        legal  = 1'b0;
        iclass = IC_SEQ;
        if (instr == 32'h0) begin
            legal = 1'b1;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_ADD, FN_SUB, FN_SLT: begin
                            legal        = 1'b1;
                            ctrl.reg_wr  = 1'b1;
                            ctrl.reg_dst = 1'b1;
                            ctrl.alu_src = 1'b1;
                            ctrl.alu     = (funct == FN_ADD) ? ALU_ADD :
                                           (funct == FN_SUB) ? ALU_SUB : ALU_SLT;
                        end
                        FN_JR: begin
                            legal  = 1'b1;
                            iclass = IC_JR;
                        end
                        default: legal = 1'b0;
                    endcase
                end
                OP_ADDI, OP_XORI: begin
                    legal       = 1'b1;
                    ctrl.reg_wr = 1'b1;
                    ctrl.alu    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                end
                OP_LW: begin
                    legal           = 1'b1;
                    ctrl.reg_wr     = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                OP_SW: begin
                    legal       = 1'b1;
                    ctrl.mem_wr = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    legal        = 1'b1;
                    ctrl.alu_src = 1'b1;
                    ctrl.alu     = ALU_SUB;
                    iclass       = (opcode == OP_BEQ) ? IC_BEQ : IC_BNE;
                end
                OP_J: begin
                    legal  = 1'b1;
                    iclass = IC_JUMP;
                end
                OP_JAL: begin
                    legal       = 1'b1;
                    ctrl.reg_wr = 1'b1;
                    ctrl.jl     = 1'b1;
                    iclass      = IC_JUMP;
                end
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch/decode stage: PC register, RUN/HALT control, next-PC selection and
// write-enable gating. Optional retired-instruction counter via IFU_RETIRE_COUNT_EN.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_valid,
    input  logic        zero,
    input  logic [31:0] jRrs,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        RegWr,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic [2:0]  ALUCntrl,
    output logic        MemWr,
    output logic        MemToReg,
    output logic        jl,
    output logic [31:0] pcStore,
`ifdef IFU_RETIRE_COUNT_EN
    output logic [31:0] retired_count,
`endif
    output logic        halted
);

    logic [31:0] pc_q, pc_d;
    state_e      state_q, state_d;
    ctrl_t       ctrl;
    logic        legal;
    iclass_e     iclass;
    logic        active;
    logic        retire;
    logic [31:0] pc_plus4;
    logic [31:0] pc_target;

    instruction_decoder u_decoder (
        .instr  (imem_data),
        .ctrl   (ctrl),
        .legal  (legal),
        .iclass (iclass)
    );

    assign rs    = imem_data[25:21];
    assign rt    = imem_data[20:16];
    assign rd    = imem_data[15:11];
    assign imm16 = imem_data[15:0];

    // Only a valid word seen in RUN outside reset may commit anything.
    assign active = (state_q == ST_RUN) && imem_valid && !reset;
    assign retire = active && legal;

    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign pcStore   = pc_plus4;
    assign halted    = (state_q == ST_HALT);

    assign RegWr    = ctrl.reg_wr & retire;
    assign MemWr    = ctrl.mem_wr & retire;
    assign RegDst   = ctrl.reg_dst;
    assign ALUSrc   = ctrl.alu_src;
    assign ALUCntrl = ctrl.alu;
    assign MemToReg = ctrl.mem_to_reg;
    assign jl       = ctrl.jl;

    always_comb begin
        pc_target = pc_plus4;
        case (iclass)
            IC_BEQ:  if (zero)  pc_target = pc_plus4 + branch_offset(imem_data[15:0]);
            IC_BNE:  if (!zero) pc_target = pc_plus4 + branch_offset(imem_data[15:0]);
            IC_JUMP: pc_target = {pc_plus4[31:28], imem_data[25:0], 2'b00};
            IC_JR:   pc_target = jRrs;
            default: pc_target = pc_plus4;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (active) begin
            if (legal) begin
                pc_d = pc_target;
            end else begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef IFU_RETIRE_COUNT_EN
    logic [31:0] retired_count_q, retired_count_d;

    assign retired_count_d = retire ? retired_count_q + 32'd1 : retired_count_q;
    assign retired_count   = retired_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count_q <= 32'd0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a reference model checked every
// cycle, plus directed literal expectations. Build with IFU_RETIRE_COUNT_EN to cover the counter.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'hFC00_0000;
    logic        imem_valid = 1'b1;
    logic        zero = 1'b0;
    logic [31:0] jRrs = 32'h0;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        RegWr, RegDst, ALUSrc, MemWr, MemToReg, jl, halted;
    logic [2:0]  ALUCntrl;
    logic [31:0] pcStore;
`ifdef IFU_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    int checks = 0;
    int failures = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_valid(imem_valid), .zero(zero), .jRrs(jRrs),
        .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
        .RegWr(RegWr), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUCntrl(ALUCntrl),
        .MemWr(MemWr), .MemToReg(MemToReg), .jl(jl), .pcStore(pcStore),
`ifdef IFU_RETIRE_COUNT_EN
        .retired_count(retired_count),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       legal;
        logic       regwr;
        logic       regdst;
        logic       alusrc;
        logic [2:0] alu;
        logic       memwr;
        logic       memtoreg;
        logic       jl;
    } exp_ctl_t;

    // Control table straight from the instruction list.
    function automatic exp_ctl_t ref_ctl(input logic [31:0] w);
        exp_ctl_t c = '0;
        logic [5:0] op = w[31:26];
        logic [5:0] fn = w[5:0];
        if (w == 32'h0)                     c.legal = 1;
        else if (op == 6'h00 && fn == 6'h20) c = '{1, 1, 1, 1, 3'd0, 0, 0, 0};
        else if (op == 6'h00 && fn == 6'h22) c = '{1, 1, 1, 1, 3'd1, 0, 0, 0};
        else if (op == 6'h00 && fn == 6'h2a) c = '{1, 1, 1, 1, 3'd3, 0, 0, 0};
        else if (op == 6'h00 && fn == 6'h08) c.legal = 1;
        else if (op == 6'h08)               c = '{1, 1, 0, 0, 3'd0, 0, 0, 0};
        else if (op == 6'h0e)               c = '{1, 1, 0, 0, 3'd2, 0, 0, 0};
        else if (op == 6'h23)               c = '{1, 1, 0, 0, 3'd0, 0, 1, 0};
        else if (op == 6'h2b)               c = '{1, 0, 0, 0, 3'd0, 1, 0, 0};
        else if (op == 6'h04 || op == 6'h05) c = '{1, 0, 0, 1, 3'd1, 0, 0, 0};
        else if (op == 6'h02)               c.legal = 1;
        else if (op == 6'h03)               c = '{1, 1, 0, 0, 3'd0, 0, 0, 1};
        return c;
    endfunction

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic z, input logic [31:0] j);
        logic [31:0] seq = pc + 32'd4;
        logic signed [31:0] off = 32'(signed'(w[15:0])) * 4;
        logic [5:0] op = w[31:26];
        if (w != 0 && op == 6'h00 && w[5:0] == 6'h08) return j;
        if ((op == 6'h04 && z) || (op == 6'h05 && !z)) return seq + off;
        if (op == 6'h02 || op == 6'h03) return {seq[31:28], w[25:0], 2'b00};
        return seq;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model state, advanced on each rising edge.
    logic [31:0] m_pc = 0;
    logic        m_halted = 0;
    logic [31:0] m_count = 0;
    logic        m_known = 0;

    always @(posedge clk) begin
        exp_ctl_t c;
        c = ref_ctl(imem_data);
        if (reset) begin
            m_pc = 32'h0; m_halted = 0; m_count = 0; m_known = 1;
        end else if (m_known && !m_halted && imem_valid) begin
            if (!c.legal) m_halted = 1;
            else begin
                m_pc = ref_next(m_pc, imem_data, zero, jRrs);
                m_count = m_count + 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_ctl_t c;
        logic live;
        if (m_known) begin
            c = ref_ctl(imem_data);
            live = !reset && !m_halted && imem_valid;
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_halted", 32'(halted), 32'(m_halted));
            chk("m_pcStore", pcStore, m_pc + 32'd4);
            chk("m_fields", {rs, rt, rd, imm16}, {imem_data[25:11], imem_data[15:0]});
            chk("m_RegWr", 32'(RegWr), 32'(live & c.regwr));
            chk("m_MemWr", 32'(MemWr), 32'(live & c.memwr));
            chk("m_RegDst", 32'(RegDst), 32'(c.regdst));
            chk("m_ALUSrc", 32'(ALUSrc), 32'(c.alusrc));
            chk("m_ALUCntrl", 32'(ALUCntrl), 32'(c.alu));
            chk("m_MemToReg", 32'(MemToReg), 32'(c.memtoreg));
            chk("m_jl", 32'(jl), 32'(c.jl));
`ifdef IFU_RETIRE_COUNT_EN
            chk("m_retired_count", retired_count, m_count);
`endif
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction
    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, fn};
    endfunction
    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] a);
        return {op, a};
    endfunction

    // Apply one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic drive(input logic r, input logic [31:0] w, input logic v,
                         input logic z, input logic [31:0] j);
        @(posedge clk);
        #1;
        reset = r; imem_data = w; imem_valid = v; zero = z; jRrs = j;
        @(negedge clk);
        $display("cycle t=%0t reset=%0b word=%h valid=%0b addr=%h halted=%0b",
                 $time, r, w, v, imem_addr, halted);
    endtask

    localparam logic [31:0] ILL = 32'hFC00_0000;

    initial begin
        logic [31:0] sw_w;
        sw_w = itype(6'h2b, 16'h0010);

        for (int i = 0; i < 2; i++) begin
            drive(1, ILL, 1, 0, 0);
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_halted", 32'(halted), 0);
            chk("rst_RegWr", 32'(RegWr), 0);
        end
        drive(0, itype(6'h08, 16'h0005), 1, 0, 0);
        chk("addi0_addr", imem_addr, 32'h0);
        chk("addi0_RegWr", 32'(RegWr), 1);
        chk("addi0_ALUSrc", 32'(ALUSrc), 0);
        chk("addi0_ALUCntrl", 32'(ALUCntrl), 0);
        drive(0, itype(6'h08, 16'h0005), 1, 0, 0);
        chk("addi1_addr", imem_addr, 32'h4);
        drive(0, jtype(6'h03, 26'h40), 1, 0, 0);
        chk("jal_addr", imem_addr, 32'h8);
        chk("jal_jl", 32'(jl), 1);
        chk("jal_RegWr", 32'(RegWr), 1);
        chk("jal_pcStore", pcStore, 32'hC);
        drive(0, rtype(6'h08), 1, 0, 32'h200);
        chk("jr_addr", imem_addr, 32'h100);
        chk("jr_RegWr", 32'(RegWr), 0);
        drive(0, rtype(6'h08), 1, 0, 32'h10);
        chk("jr_target", imem_addr, 32'h200);
        drive(0, itype(6'h04, 16'h0003), 1, 1, 0);
        chk("beq_t_addr", imem_addr, 32'h10);
        drive(0, jtype(6'h02, 26'h4), 1, 0, 0);
        chk("beq_taken", imem_addr, 32'h20);
        drive(0, itype(6'h04, 16'h0003), 1, 0, 0);
        chk("beq_nt_addr", imem_addr, 32'h10);
        drive(0, jtype(6'h02, 26'h4), 1, 0, 0);
        chk("beq_not_taken", imem_addr, 32'h14);
        drive(0, itype(6'h05, 16'hFFFF), 1, 0, 0);
        chk("bne_addr", imem_addr, 32'h10);
        drive(0, itype(6'h05, 16'hFFFF), 1, 1, 0);
        chk("bne_self_loop", imem_addr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            drive(0, sw_w, 0, 0, 0);
            chk("stall_addr", imem_addr, 32'h14);
            chk("stall_MemWr", 32'(MemWr), 0);
        end
        drive(0, sw_w, 1, 0, 0);
        chk("sw_addr", imem_addr, 32'h14);
        chk("sw_MemWr", 32'(MemWr), 1);
        drive(0, rtype(6'h08), 1, 0, 32'hFFFF_FFFC);
        chk("sw_next", imem_addr, 32'h18);
        drive(0, rtype(6'h20), 1, 0, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pcStore", pcStore, 32'h0);
        chk("add_RegDst", 32'(RegDst), 1);
        drive(0, 32'h0, 1, 0, 0);
        chk("wrap_next", imem_addr, 32'h0);
        chk("nop_RegWr", 32'(RegWr), 0);
        drive(0, rtype(6'h22), 1, 0, 0);
        chk("sub_ALUCntrl", 32'(ALUCntrl), 1);
        drive(0, rtype(6'h2a), 1, 0, 0);
        chk("slt_ALUCntrl", 32'(ALUCntrl), 3);
        drive(0, itype(6'h23, 16'h0004), 1, 0, 0);
        chk("lw_MemToReg", 32'(MemToReg), 1);
        drive(0, itype(6'h0e, 16'h00FF), 1, 0, 0);
        chk("xori_ALUCntrl", 32'(ALUCntrl), 2);
        drive(0, jtype(6'h02, 26'h9), 1, 0, 0);
        chk("j_addr", imem_addr, 32'h14);
        drive(0, ILL, 1, 0, 0);
        chk("ill_addr", imem_addr, 32'h24);
        chk("ill_RegWr", 32'(RegWr), 0);
        chk("ill_MemWr", 32'(MemWr), 0);
        chk("ill_halted", 32'(halted), 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, sw_w, 1, 0, 0);
            chk("halt_addr", imem_addr, 32'h24);
            chk("halt_halted", 32'(halted), 1);
            chk("halt_MemWr", 32'(MemWr), 0);
`ifdef IFU_RETIRE_COUNT_EN
            chk("halt_count", retired_count, 32'd20);
`endif
        end
        drive(1, ILL, 1, 0, 0);
        drive(0, itype(6'h08, 16'h0001), 1, 0, 0);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_halted", 32'(halted), 0);
        chk("post_rst_RegWr", 32'(RegWr), 1);
`ifdef IFU_RETIRE_COUNT_EN
        chk("post_rst_count", retired_count, 32'd0);
`endif
        drive(0, itype(6'h08, 16'h0001), 1, 0, 0);
        chk("post_rst_next", imem_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
